// File: rtl/clock_pkg.sv
// clock_pkg: shared state type, BCD digit type and digit limits for the
// alarm-clock time path. Imported by time_set_ctrl and its helpers.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_EDIT_HT = 3'd1,
        ST_EDIT_HU = 3'd2,
        ST_EDIT_MT = 3'd3,
        ST_EDIT_MU = 3'd4,
        ST_COMMIT  = 3'd5
    } set_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t HT_MAX_24  = 4'd2;
    localparam bcd_t HU_MAX_HT2 = 4'd3;
    localparam bcd_t MT_MAX     = 4'd5;
    localparam bcd_t DIGIT_MAX  = 4'd9;
    localparam bcd_t HT_MAX_12  = 4'd1;
    localparam bcd_t HU_MAX_HT1 = 4'd2;

    // Next value of a digit cycling lo..hi; a value at or above hi wraps to lo.
    function automatic bcd_t bcd_wrap_inc(input bcd_t d, input bcd_t lo, input bcd_t hi);
        return (d >= hi) ? lo : d + 4'd1;
    endfunction

endpackage

// File: rtl/set_timeout_ctr.sv
// set_timeout_ctr: idle-second counter for an abandoned time edit.
// Counts tick pulses, clears on clr, and flags expire on the tick that
// reaches TIMEOUT_S. Only used when SET_TIMEOUT_EN is defined.
module set_timeout_ctr #(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic clk,
    input  logic resetn,
    input  logic tick,
    input  logic clr,
    output logic expire
);

    localparam int unsigned W = $clog2(TIMEOUT_S + 1);

    logic [W-1:0] cnt;

    // Expire on the tick that would make the count reach TIMEOUT_S.
    assign expire = tick & ~clr & (cnt == W'(TIMEOUT_S - 1));

    // Idle tick counter; any clear restarts the idle interval.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: forwards the 1 Hz tick to the seconds chain while running,
// and runs the button-driven hour/minute edit sequence that ends in a single
// set_o load of {stage, 8'h00} into all six digit registers.
// Optional feature: define SET_TIMEOUT_EN to abandon an idle edit after
// TIMEOUT_S seconds (otherwise edits persist until committed).
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOURS_24  = 1,
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_ok,
    input  logic [23:0] cur_time,
    output logic        run_inc,
    output logic        set_o,
    output logic [23:0] set_time,
    output logic [3:0]  edit_sel
);

    localparam bit   H24    = (HOURS_24 != 0);
    localparam bcd_t HT_TOP = H24 ? HT_MAX_24 : HT_MAX_12;

    set_state_t state, state_nxt;
    bcd_t       ht, hu, mt, mu;
    bcd_t       ht_nxt, hu_nxt, mt_nxt, mu_nxt;
    logic [3:0] sel_nxt;
    logic       timeout_hit;

    // Seconds of cur_time are never staged.
    logic unused_sec;
    assign unused_sec = ^cur_time[7:0];

    function automatic bcd_t hu_max(input bcd_t t);
        if (H24) return (t == HT_MAX_24) ? HU_MAX_HT2 : DIGIT_MAX;
        else     return (t == HT_MAX_12) ? HU_MAX_HT1 : DIGIT_MAX;
    endfunction

    function automatic bcd_t hu_min(input bcd_t t);
        return (!H24 && t == 4'd0) ? 4'd1 : 4'd0;
    endfunction

    // Pull an hour-units digit into the legal range for the given tens digit.
    function automatic bcd_t hu_fit(input bcd_t t, input bcd_t u);
        if (u > hu_max(t)) return hu_max(t);
        if (u < hu_min(t)) return hu_min(t);
        return u;
    endfunction

`ifdef SET_TIMEOUT_EN
    logic in_edit;
    logic btn_any;
    assign in_edit = (state == ST_EDIT_HT) || (state == ST_EDIT_HU) ||
                     (state == ST_EDIT_MT) || (state == ST_EDIT_MU);
    assign btn_any = btn_mode | btn_up | btn_ok;

    set_timeout_ctr #(.TIMEOUT_S(TIMEOUT_S)) u_timeout (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick_1hz & in_edit),
        .clr    (~in_edit | btn_any),
        .expire (timeout_hit)
    );
`else
    localparam int unsigned unused_timeout_s = TIMEOUT_S;
    assign timeout_hit = 1'b0;
`endif

    // The clock only advances while no edit or commit is in progress.
    assign run_inc = tick_1hz & (state == ST_RUN);

    // Next state and staged digits; priority btn_ok > btn_mode > btn_up > timeout.
    // The stage is legalised on load so every later edit keeps it in range.
    always_comb begin
        state_nxt = state;
        ht_nxt    = ht;
        hu_nxt    = hu;
        mt_nxt    = mt;
        mu_nxt    = mu;
        case (state)
            ST_RUN: begin
                if (btn_mode) begin
                    state_nxt = ST_EDIT_HT;
                    ht_nxt    = (cur_time[23:20] > HT_TOP) ? HT_TOP : cur_time[23:20];
                    hu_nxt    = hu_fit(ht_nxt, cur_time[19:16]);
                    mt_nxt    = (cur_time[15:12] > MT_MAX) ? MT_MAX : cur_time[15:12];
                    mu_nxt    = (cur_time[11:8] > DIGIT_MAX) ? DIGIT_MAX : cur_time[11:8];
                end
            end
            ST_EDIT_HT, ST_EDIT_HU, ST_EDIT_MT, ST_EDIT_MU: begin
                if (btn_ok) begin
                    state_nxt = ST_COMMIT;
                end else if (btn_mode) begin
                    case (state)
                        ST_EDIT_HT: state_nxt = ST_EDIT_HU;
                        ST_EDIT_HU: state_nxt = ST_EDIT_MT;
                        ST_EDIT_MT: state_nxt = ST_EDIT_MU;
                        default:    state_nxt = ST_COMMIT;
                    endcase
                end else if (btn_up) begin
                    case (state)
                        ST_EDIT_HT: begin
                            ht_nxt = bcd_wrap_inc(ht, 4'd0, HT_TOP);
                            hu_nxt = hu_fit(ht_nxt, hu);
                        end
                        ST_EDIT_HU: hu_nxt = bcd_wrap_inc(hu, hu_min(ht), hu_max(ht));
                        ST_EDIT_MT: mt_nxt = bcd_wrap_inc(mt, 4'd0, MT_MAX);
                        default:    mu_nxt = bcd_wrap_inc(mu, 4'd0, DIGIT_MAX);
                    endcase
                end else if (timeout_hit) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        case (state_nxt)
            ST_EDIT_HT: sel_nxt = 4'b1000;
            ST_EDIT_HU: sel_nxt = 4'b0100;
            ST_EDIT_MT: sel_nxt = 4'b0010;
            ST_EDIT_MU: sel_nxt = 4'b0001;
            default:    sel_nxt = 4'b0000;
        endcase
    end

    // FSM state and staged hour/minute digits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_RUN;
            ht    <= '0;
            hu    <= '0;
            mt    <= '0;
            mu    <= '0;
        end else begin
            state <= state_nxt;
            ht    <= ht_nxt;
            hu    <= hu_nxt;
            mt    <= mt_nxt;
            mu    <= mu_nxt;
        end
    end

    // Registered outputs, valid for the cycle spent in the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            set_o    <= 1'b0;
            set_time <= '0;
            edit_sel <= '0;
        end else begin
            set_o    <= (state_nxt == ST_COMMIT);
            set_time <= (state_nxt == ST_COMMIT) ? {ht_nxt, hu_nxt, mt_nxt, mu_nxt, 8'h00} : '0;
            edit_sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: runs a 24-hour and a 12-hour instance side by side on the
// same stimulus and compares both against a digit/hour-value reference model.
// Timeout checks apply when SET_TIMEOUT_EN is defined (TIMEOUT_S = 3).
module tb_time_set_ctrl;

    localparam int unsigned TO = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tick_1hz, btn_mode, btn_up, btn_ok;
    logic [23:0] cur_time;

    logic        run_inc_v  [2];
    logic        set_o_v    [2];
    logic [23:0] set_time_v [2];
    logic [3:0]  edit_sel_v [2];

    always #5 clk = ~clk;

    time_set_ctrl #(.HOURS_24(1), .TIMEOUT_S(TO)) dut_h24 (
        .clk(clk), .resetn(resetn), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
        .btn_up(btn_up), .btn_ok(btn_ok), .cur_time(cur_time),
        .run_inc(run_inc_v[0]), .set_o(set_o_v[0]), .set_time(set_time_v[0]),
        .edit_sel(edit_sel_v[0])
    );

    time_set_ctrl #(.HOURS_24(0), .TIMEOUT_S(TO)) dut_h12 (
        .clk(clk), .resetn(resetn), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
        .btn_up(btn_up), .btn_ok(btn_ok), .cur_time(cur_time),
        .run_inc(run_inc_v[1]), .set_o(set_o_v[1]), .set_time(set_time_v[1]),
        .edit_sel(edit_sel_v[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 = running, 1..4 = editing HT/HU/MT/MU, 5 = commit cycle.
    // Index 0 is the 24-hour instance, index 1 the 12-hour instance.
    int mst  [2];
    int dg   [2][4];
    int idle [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hour_ok(input int k, input int h);
        return (k == 0) ? (h >= 0 && h <= 23) : (h >= 1 && h <= 12);
    endfunction

    // Adjust the hour units so the staged hour is a legal clock hour.
    task automatic fix_hour(input int k);
        int h;
        h = dg[k][0] * 10 + dg[k][1];
        if (k == 0) begin
            if (h > 23) dg[k][1] = 3;
        end else begin
            if (h > 12)     dg[k][1] = 2;
            else if (h < 1) dg[k][1] = 1;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mst[k]  = 0;
            idle[k] = 0;
            for (int d = 0; d < 4; d++) dg[k][d] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit t, input bit m, input bit u, input bit o,
                              input logic [23:0] ct);
        int ht_lim;
        int v;
        ht_lim = (k == 0) ? 2 : 1;
        case (mst[k])
            0: begin
                if (m) begin
                    v = int'(ct[23:20]); dg[k][0] = (v > ht_lim) ? ht_lim : v;
                    v = int'(ct[19:16]); dg[k][1] = (v > 9) ? 9 : v;
                    fix_hour(k);
                    v = int'(ct[15:12]); dg[k][2] = (v > 5) ? 5 : v;
                    v = int'(ct[11:8]);  dg[k][3] = (v > 9) ? 9 : v;
                    mst[k]  = 1;
                    idle[k] = 0;
                end
            end
            5: mst[k] = 0;
            default: begin
                if (o) begin
                    mst[k] = 5;
                end else if (m) begin
                    mst[k] = mst[k] + 1;
                end else if (u) begin
                    case (mst[k])
                        1: begin
                            dg[k][0] = (dg[k][0] + 1) % (ht_lim + 1);
                            fix_hour(k);
                        end
                        2: begin
                            do dg[k][1] = (dg[k][1] + 1) % 10;
                            while (!hour_ok(k, dg[k][0] * 10 + dg[k][1]));
                        end
                        3: dg[k][2] = (dg[k][2] + 1) % 6;
                        default: dg[k][3] = (dg[k][3] + 1) % 10;
                    endcase
                end
`ifdef SET_TIMEOUT_EN
                if (o || m || u) begin
                    idle[k] = 0;
                end else if (t) begin
                    idle[k]++;
                    if (idle[k] >= int'(TO)) begin
                        mst[k]  = 0;
                        idle[k] = 0;
                    end
                end
`endif
            end
        endcase
    endtask

    task automatic check_regs(input string where);
        logic [23:0] exp_time;
        logic [3:0]  exp_sel;
        logic [3:0]  top;
        for (int k = 0; k < 2; k++) begin
            top      = 4'b1000;
            exp_time = (mst[k] == 5) ? {4'(dg[k][0]), 4'(dg[k][1]), 4'(dg[k][2]), 4'(dg[k][3]), 8'h00}
                                     : 24'h0;
            exp_sel  = (mst[k] >= 1 && mst[k] <= 4) ? (top >> (mst[k] - 1)) : 4'b0000;
            check_val($sformatf("%s set_o[%0d]", where, k), 32'(set_o_v[k]), 32'(mst[k] == 5));
            check_val($sformatf("%s set_time[%0d]", where, k), 32'(set_time_v[k]), 32'(exp_time));
            check_val($sformatf("%s edit_sel[%0d]", where, k), 32'(edit_sel_v[k]), 32'(exp_sel));
        end
    endtask

    // One clock cycle: drive inputs, check run_inc before the edge, step the
    // model at the edge, check registered outputs just after it.
    task automatic cycle(input bit t, input bit m, input bit u, input bit o);
        tick_1hz = t; btn_mode = m; btn_up = u; btn_ok = o;
        #1;
        for (int k = 0; k < 2; k++)
            check_val($sformatf("run_inc[%0d]", k), 32'(run_inc_v[k]), 32'(t && mst[k] == 0));
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, t, m, u, o, cur_time);
        #1;
        check_regs("cyc");
        tick_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_ok = 1'b0;
    endtask

    task automatic async_reset_check(input string where);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_regs(where);
        for (int k = 0; k < 2; k++)
            check_val($sformatf("%s run_inc[%0d]", where, k), 32'(run_inc_v[k]), 32'h0);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rand_time();
        int h, mi, s;
        if ($urandom_range(0, 7) == 0) return 24'($urandom);
        h  = $urandom_range(0, 23);
        mi = $urandom_range(0, 59);
        s  = $urandom_range(0, 59);
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin
        resetn = 1'b0;
        tick_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_ok = 1'b0;
        cur_time = 24'h0;
        model_reset();
        #1;
        check_regs("reset");
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        // Ticks forwarded in RUN.
        repeat (3) cycle(1, 0, 0, 0);

        // Edit from 12:34 to 07:45 and commit; a tick during COMMIT is dropped.
        cur_time = 24'h123456;
        cycle(0, 1, 0, 0);
        cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        repeat (5) cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        check_val("commit_0745", 32'(set_time_v[0]), 32'h074500);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // 19:50: HT 1->2 clamps HU to 3, then HU wraps 3->0.
        cur_time = 24'h195000;
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        check_val("commit_2050", 32'(set_time_v[0]), 32'h205000);
        cycle(0, 0, 0, 0);

        // btn_ok beats btn_mode in EDIT_HT; tick with btn_mode in RUN still forwarded.
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 1);
        check_val("ok_over_mode", 32'(set_o_v[0]), 32'h1);
        cycle(0, 0, 0, 0);

`ifdef SET_TIMEOUT_EN
        cycle(0, 1, 0, 0);
        repeat (TO) cycle(1, 0, 0, 0);
        check_val("timeout_sel", 32'(edit_sel_v[0]), 32'h0);
        cycle(1, 0, 0, 0);
`endif

        // Asynchronous reset mid-edit and during COMMIT.
        cur_time = 24'h081500;
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        async_reset_check("rst_edit");
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        async_reset_check("rst_commit");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cur_time = rand_time();
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Controller that sequences the alarm clock's BCD time-digit registers. In normal operation it forwards the 1 Hz tick as the increment to the seconds-units register. On button request it freezes the clock, stages hour/minute digits for user editing, then commits the staged time to every digit register with one load pulse. It sits between the debounced button logic and the six-register time chain.

## Interface
Parameters:
- HOURS_24, default 1: 1 selects 00–23 hour format; 0 selects 01–12.
- TIMEOUT_S, default 30: idle seconds before an edit is abandoned (only with SET_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- tick_1hz  in  1  single-cycle 1 Hz strobe
- btn_mode  in  1  single-cycle debounced pulse: enter edit / advance digit
- btn_up  in  1  single-cycle debounced pulse: increment edited digit
- btn_ok  in  1  single-cycle debounced pulse: commit now
- cur_time  in  24  live BCD time {hr_T, hr_U, min_T, min_U, sec_T, sec_U}
- run_inc  out  1  increment to the seconds-units register
- set_o  out  1  load pulse to all six digit registers
- set_time  out  24  BCD value loaded on set_o; the seconds nibbles are always 0
- edit_sel  out  4  one-hot edited digit {HT, HU, MT, MU} for display blinking

## Operation
- States: RUN, EDIT_HT, EDIT_HU, EDIT_MT, EDIT_MU, COMMIT.
- RUN:
  - run_inc = tick_1hz.
  - btn_mode moves to EDIT_HT and loads the 16-bit stage from cur_time[23:8].
- EDIT_*:
  - run_inc = 0; ticks are dropped, not queued.
  - btn_up increments the selected staged digit with wrap.
  - btn_mode advances HT → HU → MT → MU. btn_mode in EDIT_MU goes to COMMIT.
  - btn_ok in any edit state goes to COMMIT.
- Button priority within one cycle: btn_ok > btn_mode > btn_up.
- COMMIT:
  - Lasts one cycle. set_o = 1 and set_time = {stage, 8'h00}.
  - The next state is RUN.
- Digit wrap ranges, HOURS_24 = 1:
  - HT 0..2.
  - HU 0..9, or 0..3 when HT = 2.
  - MT 0..5.
  - MU 0..9.
- Digit wrap ranges, HOURS_24 = 0:
  - HT 0..1.
  - HU 1..9 when HT = 0; 0..2 when HT = 1.
- Clamp on HT change:
  - HOURS_24 = 1: HU > 3 with HT = 2 forces HU to 3.
  - HOURS_24 = 0: HU > 2 with HT = 1 forces HU to 2; HU = 0 with HT = 0 forces HU to 1.
- Stage arithmetic is 4-bit BCD per digit. A staged value outside its range never reaches set_time.
- edit_sel is one-hot in EDIT_* states and 0 in RUN and COMMIT.

## Timing
- Reset values:
  - State RUN, stage 0.
  - run_inc 0, set_o 0, set_time 0, edit_sel 0.
- Reset mid-edit or in COMMIT returns to RUN immediately, with no set_o pulse.
- Registered outputs: set_o, set_time, edit_sel.
- run_inc is combinational: tick_1hz AND (state == RUN).
- Button at edge N:
  - The state or stage update is visible after edge N.
  - set_o is high for exactly the cycle following the accepting edge.
- A tick coinciding with btn_mode in RUN is still forwarded; the edit begins on the next cycle.
- A tick in the COMMIT cycle is dropped, so the digit registers see set without inc.
- cur_time is sampled only on the RUN → EDIT_HT transition.

## Configuration
- SET_TIMEOUT_EN defined:
  - An idle counter counts tick_1hz in EDIT_* states and clears on any button pulse.
  - Reaching TIMEOUT_S returns the FSM to RUN without COMMIT. The stage is discarded and the clock resumes.
- Not defined: there is no counter and edit states persist indefinitely.

## Structure
- Shared package clock_pkg holds:
  - the state enum typedef;
  - the bcd_t (4-bit) typedef;
  - digit limit constants (HT_MAX_24 = 2, HU_MAX_HT2 = 3, MT_MAX = 5, DIGIT_MAX = 9, HT_MAX_12 = 1, HU_MAX_HT1 = 2).
- One sub-module, set_timeout_ctr: idle tick counter with clear, asserting expire. It is instantiated only under SET_TIMEOUT_EN.

## Test plan
- Reset, then 3 ticks in RUN → run_inc pulses 3 times; set_o stays 0.
- cur_time = 0x123456, then btn_mode, btn_up ×2 → stage HT wraps 1→2→0, edit_sel = 4'b1000, run_inc suppressed.
- HOURS_24 = 1, stage 19:xx, editing HT: btn_up → HT = 2 and HU clamped to 3; btn_mode, btn_up → HU wraps 3→0.
- Edit to 07:45, then btn_ok → exactly one set_o cycle with set_time = 0x074500, then RUN.
- btn_ok and btn_mode in the same cycle in EDIT_HT → COMMIT, not EDIT_HU.
- With SET_TIMEOUT_EN, TIMEOUT_S = 3: enter edit and wait 3 ticks idle → RUN, no set_o. Assert resetn low mid-edit → all outputs 0 asynchronously.
